fp_unit_arbiter: RTL and testbench
==================================

Name: fp_unit_arbiter

Overview:
- Shares one single-operand floating-point core (e.g. the FP abs core, AXI-stream A in / result out, in-order) among N_REQ requesters in the SZ first-stage pipeline.
- Grants issue slots round-robin and tags each issued operand with its requester index in an in-order tag FIFO.
- Routes each core result back to the requester that issued it.
- Applies result-side backpressure per requester and caps the number of in-flight operations.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width (IEEE-754 single).
- DEPTH, 16, tag FIFO depth = max in-flight ops; power of two; ≥ core latency+1 for full throughput.
- ID_W, $clog2(N_REQ), requester tag width (derived, not overridden).

Ports:
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, N_REQ, per-requester operand valid.
- req_ready, out, N_REQ, per-requester operand accepted.
- req_data, in, N_REQ*DATA_W, operands; requester i uses bits [i*DATA_W +: DATA_W].
- res_valid, out, N_REQ, per-requester result valid.
- res_ready, in, N_REQ, per-requester result accept.
- res_data, out, DATA_W, result word, shared by all requesters (qualified by res_valid).
- core_a_tvalid, out, 1, to core s_axis_a_tvalid.
- core_a_tready, in, 1, from core s_axis_a_tready.
- core_a_tdata, out, DATA_W, to core s_axis_a_tdata.
- core_r_tvalid, in, 1, from core m_axis_result_tvalid.
- core_r_tready, out, 1, to core m_axis_result_tready.
- core_r_tdata, in, DATA_W, from core m_axis_result_tdata.
- inflight, out, $clog2(DEPTH)+1, current tag FIFO occupancy.
- err_orphan, out, 1, sticky: core produced a result with no outstanding tag.

Behaviour:
- Reset (rst=1 at posedge):
  - RR pointer ← 0, tag FIFO empty, inflight ← 0, err_orphan ← 0.
  - All valid/ready outputs are low during and after the reset cycle until inputs dictate otherwise.
- Issue side (combinational grant, registered state):
  - Grant = first i with req_valid[i]=1, searching from ptr upward with wrap N_REQ-1→0.
  - core_a_tvalid = |req_valid & !fifo_full.
  - core_a_tdata = operand of the granted requester.
  - req_ready[i] = (i==grant) & core_a_tready & !fifo_full; all others 0.
- Issue handshake (core_a_tvalid & core_a_tready):
  - Push grant index into the tag FIFO.
  - ptr ← (grant+1) mod N_REQ.
  - With no handshake, ptr holds.
- Fairness: a requester held valid is granted within N_REQ issue handshakes.
- FIFO full: no issue, even if a pop occurs in the same cycle. This is a deliberate simplification; the one-cycle bubble is acceptable.
- Result side:
  - head = FIFO front tag.
  - res_valid[i] = core_r_tvalid & !fifo_empty & (head==i).
  - res_data = core_r_tdata, unregistered passthrough.
  - core_r_tready = !fifo_empty & res_ready[head].
  - Pop on core_r_tvalid & core_r_tready.
  - A stalled requester stalls the core output. In-order semantics mean head-of-line blocking is intended.
- Simultaneous push and pop (not full): occupancy unchanged, both take effect.
- Orphan: core_r_tvalid=1 while fifo_empty sets err_orphan. It stays set until rst. core_r_tready stays 0 in this case.
- inflight = FIFO count; it changes by +1, -1 or 0 per cycle.
- Latency:
  - Zero cycles added on the issue path.
  - Zero cycles added on the return path.
  - End-to-end latency = core latency.
- Reset mid-operation: all in-flight tags are discarded. The core must be reset by the same rst. Results arriving after reset with an empty FIFO flag err_orphan.
- Requirements on requesters: req_data must stay stable while req_valid=1 and not ready. req_valid must not drop before ready (AXI-stream rules).

Decomposition:
- Shared package sz_fp_pkg holds:
  - DATA_W localparam;
  - fp_word_t typedef (logic [31:0]);
  - the rr_next function (wrap-around pointer increment).
- Sub-module fp_tag_fifo holds:
  - synchronous single-clock FIFO, width ID_W, depth DEPTH;
  - ports push, pop, din, dout (show-ahead front), full, empty, count.
- The arbiter instantiates fp_tag_fifo.
- The FP core stays outside this block. The parent wires it.

Test Plan:
- Single requester: req_valid[2]=1 with data 0xC0490FDB, core latency 8 → res_valid[2] after 8 cycles with 0x40490FDB (abs); inflight 0→1→0.
- All four valid every cycle, all res_ready=1 → grants 0,1,2,3,0,1… one per cycle; each requester gets exactly 25 of 100 results, in issue order.
- res_ready[1]=0 while its result is at head → core_r_tready=0, later results held. Release after 5 cycles → all drain in order, no loss.
- Stall all result ready for 30 cycles with requesters continuously valid → inflight saturates at 16, req_ready all 0. On release, full throughput resumes.
- Assert rst with 6 ops in flight → inflight=0, ptr=0, outputs low next cycle. A stray core result afterwards sets err_orphan=1 until the next rst.
- core_a_tready=0 for 4 cycles with req_valid[3]=1 → req_ready[3]=0, ptr unchanged, no tag pushed. Grant to 3 on the first ready cycle.

Source files
------------

// File: rtl/fp_unit_arbiter_pkg.sv
// Shared definitions for the SZ first-stage FP core sharing logic.
package sz_fp_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] fp_word_t;

  // Round-robin pointer increment, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/fp_unit_arbiter_tag_fifo.sv
// In-order requester tag FIFO with show-ahead output; one entry per in-flight op.
module fp_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one in-order single-operand FP core among N_REQ requesters,
// with results steered back by an in-order requester tag FIFO.
module fp_unit_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int ID_W  = $clog2(N_REQ),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        res_valid,
  input  logic [N_REQ-1:0]        res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic                    core_a_tvalid,
  input  logic                    core_a_tready,
  output logic [DATA_W-1:0]       core_a_tdata,
  input  logic                    core_r_tvalid,
  output logic                    core_r_tready,
  input  logic [DATA_W-1:0]       core_r_tdata,
  output logic [CNT_W-1:0]        inflight,
  output logic                    err_orphan
);
  import sz_fp_pkg::*;

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] head;
  logic            found;
  logic            err_orphan_reg;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Walk from ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant = ptr_reg;
    found = 1'b0;
    cand  = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
      cand = ID_W'(rr_next(32'(cand), N_REQ));
    end
  end

  assign ptr_next = ID_W'(rr_next(32'(grant), N_REQ));

  // Outputs are forced quiet while rst is high so nothing handshakes in the reset cycle.
  assign core_a_tvalid = !rst && (|req_valid) && !fifo_full;
  assign core_a_tdata  = req_data[grant*DATA_W +: DATA_W];
  assign push          = core_a_tvalid && core_a_tready;

  assign core_r_tready = !rst && !fifo_empty && res_ready[head];
  assign pop           = core_r_tvalid && core_r_tready;
  assign res_data      = core_r_tdata;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_ready[gi] = push && (grant == ID_W'(gi));
      assign res_valid[gi] = !rst && core_r_tvalid && !fifo_empty && (head == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (push) ptr_reg <= ptr_next;
      if (core_r_tvalid && fifo_empty) err_orphan_reg <= 1'b1;
    end
  end

  assign err_orphan = err_orphan_reg;

  fp_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (inflight)
  );

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with an 8-cycle in-order abs core stand-in and result scoreboard.
module tb_fp_unit_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        res_valid;
  logic [N_REQ-1:0]        res_ready;
  logic [DATA_W-1:0]       res_data;
  logic                    core_a_tvalid;
  logic                    core_a_tready;
  logic [DATA_W-1:0]       core_a_tdata;
  logic                    core_r_tvalid;
  logic                    core_r_tready;
  logic [DATA_W-1:0]       core_r_tdata;
  logic [4:0]              inflight;
  logic                    err_orphan;

  logic        model_valid = 1'b0;
  logic [31:0] model_data  = '0;
  logic        stray;

  int checks = 0;
  int errors = 0;
  int seq[N_REQ]     = '{default: 0};
  int res_cnt[N_REQ] = '{default: 0};

  always #5 clk = ~clk;

  assign core_r_tvalid = model_valid | stray;
  assign core_r_tdata  = stray ? 32'h1234_5678 : model_data;

  fp_unit_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .core_a_tvalid(core_a_tvalid), .core_a_tready(core_a_tready), .core_a_tdata(core_a_tdata),
    .core_r_tvalid(core_r_tvalid), .core_r_tready(core_r_tready), .core_r_tdata(core_r_tdata),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int i, input int s);
    return {s[0], 7'(i), 24'(s)};
  endfunction

  // Core stand-in: in-order abs, fixed latency, unlimited internal buffering.
  logic [31:0] cq_data[$];
  int          cq_due[$];
  int          cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      cq_data.delete();
      cq_due.delete();
      model_valid <= 1'b0;
    end else begin
      if (model_valid && core_r_tready) begin
        void'(cq_data.pop_front());
        void'(cq_due.pop_front());
      end
      if (core_a_tvalid && core_a_tready) begin
        cq_data.push_back({1'b0, core_a_tdata[30:0]});
        cq_due.push_back(cyc + LAT);
      end
      model_valid <= (cq_data.size() > 0) && (cq_due[0] <= cyc);
      model_data  <= (cq_data.size() > 0) ? cq_data[0] : 32'h0;
    end
  end

  // Scoreboard: results must come back in requester-issue order with abs applied.
  int          exp_id[$];
  logic [31:0] exp_dat[$];
  always @(posedge clk) begin
    if (rst) begin
      exp_id.delete();
      exp_dat.delete();
    end else begin
      if (|(res_valid & res_ready)) begin
        int idx;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (res_valid[i] && res_ready[i]) idx = i;
        chk("sb_onehot", 64'($onehot(res_valid & res_ready)), 64'd1);
        if (exp_id.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          chk("sb_id", 64'(idx), 64'(exp_id[0]));
          chk("sb_data", 64'(res_data), 64'(exp_dat[0]));
          void'(exp_id.pop_front());
          void'(exp_dat.pop_front());
          res_cnt[idx]++;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_id.push_back(i);
          exp_dat.push_back({1'b0, req_data[i*DATA_W +: 31]});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One issue cycle: present current operands, capture ready, advance the accepted ones.
  task automatic step(input bit oneshot, output logic [N_REQ-1:0] rdy);
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = mkdata(i, seq[i]);
    #1;
    rdy = req_ready;
    cycle();
    for (int i = 0; i < N_REQ; i++) begin
      if (rdy[i]) begin
        seq[i]++;
        if (oneshot) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (inflight != 0 && t < 200) begin
      cycle();
      t++;
    end
    chk(tag, 64'(inflight), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] rdy;
    int base[N_REQ];
    int t;

    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = '0;
    core_a_tready = 1'b1; stray = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_orphan", 64'(err_orphan), 64'd0);
    chk("rst_a_tvalid", 64'(core_a_tvalid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_r_tready", 64'(core_r_tready), 64'd0);

    // Single requester, latency 8
    res_ready = 4'hF;
    req_valid = 4'b0100;
    req_data[2*DATA_W +: DATA_W] = 32'hC049_0FDB;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'h4);
    chk("t1_a_tvalid", 64'(core_a_tvalid), 64'd1);
    chk("t1_a_tdata", 64'(core_a_tdata), 64'hC049_0FDB);
    cycle();
    req_valid = '0;
    #1;
    chk("t1_inflight_1", 64'(inflight), 64'd1);
    repeat (7) cycle();
    chk("t1_res_early", 64'(res_valid), 64'd0);
    cycle();
    chk("t1_res_valid", 64'(res_valid), 64'h4);
    chk("t1_res_data", 64'(res_data), 64'h4049_0FDB);
    chk("t1_r_tready", 64'(core_r_tready), 64'd1);
    cycle();
    chk("t1_inflight_0", 64'(inflight), 64'd0);
    chk("t1_res_done", 64'(res_valid), 64'd0);

    // All four valid every cycle, 100 issues
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) base[i] = res_cnt[i];
    req_valid = 4'hF;
    for (int n = 0; n < 100; n++) begin
      step(1'b0, rdy);
      chk("t2_grant", 64'(rdy), 64'(1 << (n % 4)));
    end
    req_valid = '0;
    drain("t2_drain");
    for (int i = 0; i < N_REQ; i++) chk("t2_count", 64'(res_cnt[i] - base[i]), 64'd25);

    // Head-of-line block on requester 1
    res_ready = 4'b1101;
    req_valid = 4'hF;
    repeat (4) step(1'b1, rdy);
    req_valid = '0;
    t = 0;
    while (!res_valid[1] && t < 50) begin
      cycle();
      t++;
    end
    chk("t3_seen", 64'(res_valid[1]), 64'd1);
    chk("t3_r_tready", 64'(core_r_tready), 64'd0);
    chk("t3_inflight", 64'(inflight), 64'd3);
    repeat (5) begin
      cycle();
      chk("t3_hold_valid", 64'(res_valid), 64'h2);
      chk("t3_hold_inflight", 64'(inflight), 64'd3);
    end
    res_ready = 4'hF;
    #1;
    chk("t3_release", 64'(core_r_tready), 64'd1);
    drain("t3_drain");

    // Saturate in-flight limit, then release
    res_ready = '0;
    req_valid = 4'hF;
    repeat (30) step(1'b0, rdy);
    #1;
    chk("t4_inflight_full", 64'(inflight), 64'd16);
    chk("t4_req_ready", 64'(req_ready), 64'd0);
    chk("t4_a_tvalid", 64'(core_a_tvalid), 64'd0);
    res_ready = 4'hF;
    step(1'b0, rdy);
    chk("t4_bubble", 64'(rdy), 64'd0);
    chk("t4_inflight_15", 64'(inflight), 64'd15);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, rdy);
      chk("t4_grant", 64'(rdy), 64'(1 << (k % 4)));
      chk("t4_inflight", 64'(inflight), 64'd15);
    end
    req_valid = '0;
    drain("t4_drain");

    // Reset with 6 ops in flight, then a stray result
    res_ready = '0;
    req_valid = 4'hF;
    repeat (6) step(1'b0, rdy);
    #1;
    chk("t5_inflight_6", 64'(inflight), 64'd6);
    rst = 1'b1;
    res_ready = 4'hF;
    #1;
    chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
    chk("t5_rst_a_tvalid", 64'(core_a_tvalid), 64'd0);
    chk("t5_rst_res_valid", 64'(res_valid), 64'd0);
    chk("t5_rst_r_tready", 64'(core_r_tready), 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("t5_inflight_0", 64'(inflight), 64'd0);
    chk("t5_ptr_zero", 64'(req_ready), 64'h1);
    req_valid = '0;
    #1;
    stray = 1'b1;
    #1;
    chk("t5_stray_r_tready", 64'(core_r_tready), 64'd0);
    chk("t5_stray_res_valid", 64'(res_valid), 64'd0);
    chk("t5_orphan_pre", 64'(err_orphan), 64'd0);
    cycle();
    stray = 1'b0;
    #1;
    chk("t5_orphan_set", 64'(err_orphan), 64'd1);
    repeat (3) cycle();
    chk("t5_orphan_sticky", 64'(err_orphan), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("t5_orphan_clr", 64'(err_orphan), 64'd0);

    // Core not ready for 4 cycles with requester 3 waiting
    core_a_tready = 1'b0;
    req_valid = 4'b1000;
    req_data[3*DATA_W +: DATA_W] = mkdata(3, seq[3]);
    repeat (4) begin
      #1;
      chk("t6_stall_ready", 64'(req_ready), 64'd0);
      chk("t6_stall_tvalid", 64'(core_a_tvalid), 64'd1);
      cycle();
      chk("t6_stall_inflight", 64'(inflight), 64'd0);
    end
    core_a_tready = 1'b1;
    #1;
    chk("t6_grant3", 64'(req_ready), 64'h8);
    cycle();
    seq[3]++;
    #1;
    chk("t6_inflight_1", 64'(inflight), 64'd1);
    req_valid = 4'hF;
    step(1'b1, rdy);
    chk("t6_after_wrap", 64'(rdy), 64'h1);
    req_valid = '0;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
